johnson_seq_ctrl: RTL

//  Run/stop controller for a WIDTH-stage Johnson counter used as a multiphase

---
 rtl/johnson_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/johnson_seq_ctrl.sv
// Run/stop controller for a WIDTH-stage Johnson counter driving multiphase enables.
// Sequences a programmable lap count, drains on stop, and self-corrects illegal states.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   num_laps,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic               busy,
    output logic               lap_done,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2*WIDTH-1:0] PH_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lap_done_q, lap_done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] q_adv;
    logic             lap_end;
    logic             legal;
    int unsigned      n_trans;
    int unsigned      n_ones;
    int unsigned      k_idx;

    // A Johnson pattern has at most one 0/1 boundary between adjacent stages.
    always_comb begin
        n_trans = 0;
        n_ones  = 0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (q_q[i] != q_q[i+1]) n_trans++;
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (q_q[i]) n_ones++;
        end
        legal = (n_trans <= 1);
        k_idx = q_q[WIDTH-1] ? (2 * WIDTH - n_ones) : n_ones;
    end

    assign q_adv   = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    assign lap_end = (q_adv == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            cnt_q      <= '0;
            lap_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            lap_done_q <= lap_done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        lap_done_d = 1'b0;
        err_d      = err_clr ? 1'b0 : err_q;
        if (!legal) begin
            // Recovery overrides every state and any concurrent err_clr.
            q_d     = '0;
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = num_laps;
                    end
                end
                RUN: begin
                    q_d = q_adv;
                    if (lap_end) begin
                        lap_done_d = 1'b1;
                        if (stop) begin
                            state_d = DONE;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) state_d = DONE;
                        end
                    end else if (stop) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    q_d = q_adv;
                    if (lap_end) begin
                        lap_done_d = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    q_d     = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        q        = q_q;
        phase    = legal ? (PH_ONE << k_idx) : '0;
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == DONE);
        lap_done = lap_done_q;
        err      = err_q;
    end

endmodule
